// File: rtl/aes_pkg.sv
// Shared AES GF(2^8) helpers, mode encodings and the MixColumns engine state codes.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;
    localparam logic       MODE_FWD = 1'b0;
    localparam logic       MODE_INV = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    // Inverse coefficients are built from the x2/x4/x8 chain.
    function automatic logic [7:0] gf_mul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] gf_mulb(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] gf_muld(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] gf_mule(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational single-column MixColumns / InvMixColumns; byte 0 sits in bits [0:7].
module mix_column_word
    import aes_pkg::*;
(
    input  logic        inv,
    input  logic [0:31] col_in,
    output logic [0:31] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[0:7];
    assign a1 = col_in[8:15];
    assign a2 = col_in[16:23];
    assign a3 = col_in[24:31];

    always_comb begin
        col_out = '0;
        if (inv == MODE_INV) begin
            col_out[0:7]   = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
            col_out[8:15]  = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
            col_out[16:23] = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
            col_out[24:31] = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);
        end else begin
            col_out[0:7]   = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
            col_out[8:15]  = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
            col_out[16:23] = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
            col_out[24:31] = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);
        end
    end

endmodule

// File: rtl/mix_columns_seq.sv
// Iterative MixColumns engine: COLS_PER_CYCLE columns per clock, result held until accepted.
// state | meaning
// IDLE  | ready for a new state
// BUSY  | transforming column groups
// DONE  | result valid, waiting for out_ready
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NB             = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              inv_in,
    input  logic [0:32*NB-1]  state_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:32*NB-1]  state_out
);

    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    if (NB % COLS_PER_CYCLE != 0) begin : g_bad_cfg
        $error("mix_columns_seq: COLS_PER_CYCLE must divide NB");
    end

    logic [1:0]         state;
    logic [CNT_W-1:0]   col_cnt;
    logic [0:32*NB-1]   work;
    logic [0:32*NB-1]   result;
    logic               mode;
    logic               last_group;
    logic [0:31]        col_src [COLS_PER_CYCLE];
    logic [0:31]        col_dst [COLS_PER_CYCLE];

    assign in_ready   = (state == ST_IDLE);
    assign out_valid  = (state == ST_DONE);
    assign state_out  = result;
    assign last_group = (col_cnt == CNT_W'(NB - COLS_PER_CYCLE));

    always_comb begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_src[g] = work[32*(int'(col_cnt) + g) +: 32];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        mix_column_word u_col (
            .inv     (mode),
            .col_in  (col_src[g]),
            .col_out (col_dst[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            col_cnt <= '0;
            work    <= '0;
            result  <= '0;
            mode    <= MODE_FWD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work    <= state_in;
                        mode    <= inv_in;
                        col_cnt <= '0;
                        state   <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                        result[32*(int'(col_cnt) + g) +: 32] <= col_dst[g];
                    end
                    if (last_group) begin
                        state <= ST_DONE;
                    end else begin
                        col_cnt <= col_cnt + CNT_W'(COLS_PER_CYCLE);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
